// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded control, operands, immediate, PC and register addresses
// from ID and presents them to EX one cycle later. A load sitting in EX whose
// destination is read by the instruction in ID raises Stall_o and a bubble is
// inserted. Flush_i kills the entering instruction and Hold_i freezes EX.
// Optional build macro: ID_EX_PERF_CNT_EN adds saturating stall/flush counters
// (StallCnt_o, FlushCnt_o).
//
// Control semantics, in priority order at each clock edge:
//   Flush_i  - EX slot becomes an all-zero bubble, regardless of Hold_i.
//   Hold_i   - EX slot keeps its contents. Stall_o still reflects the hazard,
//              so IF/ID also stays frozen while a dependent waits.
//   Stall_o  - EX slot becomes an all-zero bubble. The ID instruction stays in
//              IF/ID and is reloaded on the next edge.
//   else     - EX slot loads ID, with control bits gated by id_Valid_i.
module id_ex_pipe_reg #(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_Valid_i,
  input  logic              id_ALUSrc_i,
  input  logic              id_Branch_i,
  input  logic              id_MemRead_i,
  input  logic              id_MemWrite_i,
  input  logic              id_MemtoReg_i,
  input  logic              id_RegWrite_i,
  input  logic [2:0]        id_ALUOp_i,
  input  logic [DATA_W-1:0] id_RD1_i,
  input  logic [DATA_W-1:0] id_RD2_i,
  input  logic [DATA_W-1:0] id_Imm_i,
  input  logic [DATA_W-1:0] id_PC_i,
  input  logic [REG_AW-1:0] id_Rn_i,
  input  logic [REG_AW-1:0] id_Rs2_i,
  input  logic [REG_AW-1:0] id_Rd_i,
  input  logic              Flush_i,
  input  logic              Hold_i,
  output logic              Stall_o,
  output logic              ex_Valid_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_Branch_o,
  output logic              ex_MemRead_o,
  output logic              ex_MemWrite_o,
  output logic              ex_MemtoReg_o,
  output logic              ex_RegWrite_o,
  output logic [2:0]        ex_ALUOp_o,
  output logic [DATA_W-1:0] ex_RD1_o,
  output logic [DATA_W-1:0] ex_RD2_o,
  output logic [DATA_W-1:0] ex_Imm_o,
  output logic [DATA_W-1:0] ex_PC_o,
  output logic [REG_AW-1:0] ex_Rn_o,
  output logic [REG_AW-1:0] ex_Rs2_o,
  output logic [REG_AW-1:0] ex_Rd_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]       StallCnt_o,
  output logic [15:0]       FlushCnt_o
`endif
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
    logic [2:0]        aluop;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ex_slot_t;

  ex_slot_t ex_q, ex_d;
  logic     rs2_used;
  logic     hz;

  // Load-use hazard: a valid load in EX writing a real register that ID reads.
  always_comb begin
    rs2_used = ~id_ALUSrc_i | id_MemWrite_i;
    hz       = ex_q.valid & ex_q.memread & (ex_q.rd != ZERO_ADDR) &
               ((ex_q.rd == id_Rn_i) | (rs2_used & (ex_q.rd == id_Rs2_i)));
    Stall_o  = id_Valid_i & hz;
  end

  // Next EX slot contents: flush > hold > bubble > load.
  always_comb begin
    ex_d = ex_q;
    if (Flush_i) begin
      ex_d = '0;
    end else if (Hold_i) begin
      ex_d = ex_q;
    end else if (Stall_o) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = id_Valid_i;
      ex_d.alusrc   = id_ALUSrc_i   & id_Valid_i;
      ex_d.branch   = id_Branch_i   & id_Valid_i;
      ex_d.memread  = id_MemRead_i  & id_Valid_i;
      ex_d.memwrite = id_MemWrite_i & id_Valid_i;
      ex_d.memtoreg = id_MemtoReg_i & id_Valid_i;
      ex_d.regwrite = id_RegWrite_i & id_Valid_i;
      ex_d.aluop    = id_ALUOp_i & {3{id_Valid_i}};
      ex_d.rd1      = id_RD1_i;
      ex_d.rd2      = id_RD2_i;
      ex_d.imm      = id_Imm_i;
      ex_d.pc       = id_PC_i;
      ex_d.rn       = id_Rn_i;
      ex_d.rs2      = id_Rs2_i;
      ex_d.rd       = id_Rd_i;
    end
  end

  // EX slot register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_Valid_o    = ex_q.valid;
  assign ex_ALUSrc_o   = ex_q.alusrc;
  assign ex_Branch_o   = ex_q.branch;
  assign ex_MemRead_o  = ex_q.memread;
  assign ex_MemWrite_o = ex_q.memwrite;
  assign ex_MemtoReg_o = ex_q.memtoreg;
  assign ex_RegWrite_o = ex_q.regwrite;
  assign ex_ALUOp_o    = ex_q.aluop;
  assign ex_RD1_o      = ex_q.rd1;
  assign ex_RD2_o      = ex_q.rd2;
  assign ex_Imm_o      = ex_q.imm;
  assign ex_PC_o       = ex_q.pc;
  assign ex_Rn_o       = ex_q.rn;
  assign ex_Rs2_o      = ex_q.rs2;
  assign ex_Rd_o       = ex_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: stalls that actually freeze the front end, and
  // flushes that kill a real instruction.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall_o && !Hold_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (Flush_i && ex_q.valid && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus a randomized run, all
// checked against a behavioural model of the EX slot.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
    logic [2:0]        aluop;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } slot_t;

  localparam int W = $bits(slot_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  slot_t id_s = '0;
  logic  Flush_i = 1'b0;
  logic  Hold_i = 1'b0;
  logic  Stall_o;
  logic  ex_Valid_o, ex_ALUSrc_o, ex_Branch_o, ex_MemRead_o;
  logic  ex_MemWrite_o, ex_MemtoReg_o, ex_RegWrite_o;
  logic [2:0]        ex_ALUOp_o;
  logic [DATA_W-1:0] ex_RD1_o, ex_RD2_o, ex_Imm_o, ex_PC_o;
  logic [REG_AW-1:0] ex_Rn_o, ex_Rs2_o, ex_Rd_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] StallCnt_o, FlushCnt_o;
`endif
  logic [W-1:0] dut_v;

  assign dut_v = {ex_Valid_o, ex_ALUSrc_o, ex_Branch_o, ex_MemRead_o,
                  ex_MemWrite_o, ex_MemtoReg_o, ex_RegWrite_o, ex_ALUOp_o,
                  ex_RD1_o, ex_RD2_o, ex_Imm_o, ex_PC_o,
                  ex_Rn_o, ex_Rs2_o, ex_Rd_o};

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_Valid_i    (id_s.valid),
    .id_ALUSrc_i   (id_s.alusrc),
    .id_Branch_i   (id_s.branch),
    .id_MemRead_i  (id_s.memread),
    .id_MemWrite_i (id_s.memwrite),
    .id_MemtoReg_i (id_s.memtoreg),
    .id_RegWrite_i (id_s.regwrite),
    .id_ALUOp_i    (id_s.aluop),
    .id_RD1_i      (id_s.rd1),
    .id_RD2_i      (id_s.rd2),
    .id_Imm_i      (id_s.imm),
    .id_PC_i       (id_s.pc),
    .id_Rn_i       (id_s.rn),
    .id_Rs2_i      (id_s.rs2),
    .id_Rd_i       (id_s.rd),
    .Flush_i       (Flush_i),
    .Hold_i        (Hold_i),
    .Stall_o       (Stall_o),
    .ex_Valid_o    (ex_Valid_o),
    .ex_ALUSrc_o   (ex_ALUSrc_o),
    .ex_Branch_o   (ex_Branch_o),
    .ex_MemRead_o  (ex_MemRead_o),
    .ex_MemWrite_o (ex_MemWrite_o),
    .ex_MemtoReg_o (ex_MemtoReg_o),
    .ex_RegWrite_o (ex_RegWrite_o),
    .ex_ALUOp_o    (ex_ALUOp_o),
    .ex_RD1_o      (ex_RD1_o),
    .ex_RD2_o      (ex_RD2_o),
    .ex_Imm_o      (ex_Imm_o),
    .ex_PC_o       (ex_PC_o),
    .ex_Rn_o       (ex_Rn_o),
    .ex_Rs2_o      (ex_Rs2_o),
    .ex_Rd_o       (ex_Rd_o)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .StallCnt_o    (StallCnt_o),
    .FlushCnt_o    (FlushCnt_o)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  slot_t        m = '0;
  int           mdl_stall_cnt = 0;
  int           mdl_flush_cnt = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           stall_seen = 0;

  // A load in EX blocks an ID instruction that reads its (non-XZR) result.
  function automatic logic model_hz(input slot_t e, input slot_t d);
    logic reads_rs2;
    if (!e.valid || !e.memread || e.rd == 5'd31) return 1'b0;
    reads_rs2 = !d.alusrc || d.memwrite;
    return (d.rn == e.rd) || (reads_rs2 && d.rs2 == e.rd);
  endfunction

  // An invalid ID slot travels into EX with its data but no control.
  function automatic slot_t model_load(input slot_t d);
    slot_t r;
    r = d;
    if (!d.valid) begin
      r.alusrc = 0; r.branch = 0; r.memread = 0; r.memwrite = 0;
      r.memtoreg = 0; r.regwrite = 0; r.aluop = 3'b000;
    end
    return r;
  endfunction

  function automatic slot_t mk(input logic v, input logic alusrc, input logic mrd,
                               input logic mwr, input logic rwr, input logic [2:0] op,
                               input logic [4:0] rn, input logic [4:0] rs2,
                               input logic [4:0] rd);
    slot_t r;
    r = '0;
    r.valid = v; r.alusrc = alusrc; r.memread = mrd; r.memwrite = mwr;
    r.memtoreg = mrd; r.regwrite = rwr; r.aluop = op;
    r.rd1 = {$urandom, $urandom}; r.rd2 = {$urandom, $urandom};
    r.imm = {$urandom, $urandom}; r.pc = {$urandom, $urandom};
    r.rn = rn; r.rs2 = rs2; r.rd = rd;
    return r;
  endfunction

  function automatic logic [4:0] rand_reg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  // ---------------- driver: one clock of stimulus + checks ----------------
  task automatic step(input logic fl, input logic ho);
    logic         exp_stall;
    logic [W-1:0] exp_v;
    Flush_i = fl;
    Hold_i  = ho;
    #1;
    exp_stall = id_s.valid & model_hz(m, id_s);
    n_cmp++;
    if (Stall_o !== exp_stall) begin
      n_fail++;
      $display("FAIL stall t=%0t got=%b exp=%b", $time, Stall_o, exp_stall);
    end
    if (exp_stall) stall_seen++;
    if (exp_stall && !ho && mdl_stall_cnt < 65535) mdl_stall_cnt++;
    if (fl && m.valid && mdl_flush_cnt < 65535) mdl_flush_cnt++;
    if (fl)             m = '0;
    else if (ho)        m = m;
    else if (exp_stall) m = '0;
    else                m = model_load(id_s);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dut_v !== exp_v) begin
      n_fail++;
      $display("FAIL ex_slot t=%0t got=%h exp=%h", $time, dut_v, exp_v);
    end
`ifdef ID_EX_PERF_CNT_EN
    n_cmp++;
    if (StallCnt_o !== 16'(mdl_stall_cnt) || FlushCnt_o !== 16'(mdl_flush_cnt)) begin
      n_fail++;
      $display("FAIL perf_cnt t=%0t got=%0d/%0d exp=%0d/%0d", $time,
               StallCnt_o, FlushCnt_o, mdl_stall_cnt, mdl_flush_cnt);
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd1, 5'd1, 5'd2);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (dut_v !== '0 || Stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%h stall=%b exp=0", dut_v, Stall_o);
    end
    reset_n = 1'b1;
    m = '0;
    #3;
  endtask

  task automatic test_add();
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd1, 5'd3, 5'd2);
    id_s.rd1 = 64'h5;
    id_s.rd2 = 64'h7;
    step(0, 0);
    n_cmp++;
    if (ex_ALUOp_o !== 3'b010 || ex_RegWrite_o !== 1'b1 || ex_Rd_o !== 5'd2 ||
        ex_RD1_o !== 64'h5 || ex_Valid_o !== 1'b1 || Stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL add_fields op=%b rw=%b rd=%0d rd1=%h v=%b stall=%b exp op=010 rw=1 rd=2 rd1=5 v=1 stall=0",
               ex_ALUOp_o, ex_RegWrite_o, ex_Rd_o, ex_RD1_o, ex_Valid_o, Stall_o);
    end
  endtask

  task automatic test_load_use();
    int s0;
    id_s = mk(1, 1, 1, 0, 1, 3'b000, 5'd5, 5'd0, 5'd1);   // LDUR X1
    step(0, 0);
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd1, 5'd3, 5'd2);   // ADD X2,X1,X3
    s0 = stall_seen;
    step(0, 0);
    n_cmp++;
    if (ex_Valid_o !== 1'b0 || {ex_ALUSrc_o, ex_MemRead_o, ex_RegWrite_o, ex_ALUOp_o} !== '0) begin
      n_fail++;
      $display("FAIL load_use_bubble v=%b ctl=%b exp v=0 ctl=0", ex_Valid_o,
               {ex_ALUSrc_o, ex_MemRead_o, ex_RegWrite_o, ex_ALUOp_o});
    end
    step(0, 0);
    n_cmp++;
    if (stall_seen - s0 !== 1 || ex_Valid_o !== 1'b1 || ex_Rd_o !== 5'd2) begin
      n_fail++;
      $display("FAIL load_use_once stalls=%0d v=%b rd=%0d exp stalls=1 v=1 rd=2",
               stall_seen - s0, ex_Valid_o, ex_Rd_o);
    end
  endtask

  task automatic test_zero_reg_and_store();
    id_s = mk(1, 1, 1, 0, 1, 3'b000, 5'd4, 5'd0, 5'd31);  // LDUR X31
    step(0, 0);
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd31, 5'd31, 5'd6);
    #1;
    n_cmp++;
    if (Stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL xzr_no_stall got=%b exp=0", Stall_o);
    end
    step(0, 0);
    id_s = mk(1, 1, 1, 0, 1, 3'b000, 5'd4, 5'd0, 5'd1);   // LDUR X1
    step(0, 0);
    id_s = mk(1, 1, 0, 1, 0, 3'b000, 5'd7, 5'd1, 5'd0);   // STUR X1,[X7]
    #1;
    n_cmp++;
    if (Stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL store_rs2_stall got=%b exp=1", Stall_o);
    end
    step(0, 0);
    step(0, 0);
  endtask

  task automatic test_flush_hold();
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd2, 5'd3, 5'd4);
    step(0, 0);
    step(1, 1);
    n_cmp++;
    if (ex_Valid_o !== 1'b0 || ex_RegWrite_o !== 1'b0 || ex_ALUOp_o !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_over_hold v=%b rw=%b op=%b exp all 0", ex_Valid_o, ex_RegWrite_o, ex_ALUOp_o);
    end
  endtask

  task automatic test_hold_stall();
    logic [W-1:0] held;
    id_s = mk(1, 1, 1, 0, 1, 3'b000, 5'd8, 5'd0, 5'd3);   // LDUR X3
    step(0, 0);
    held = dut_v;
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd0, 5'd3, 5'd9);   // reads X3 via Rs2
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      n_cmp++;
      if (dut_v !== held || Stall_o !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_frozen cyc=%0d got=%h stall=%b exp=%h stall=1", i, dut_v, Stall_o, held);
      end
    end
    step(0, 0);                                            // bubble
    step(0, 0);                                            // dependent loads
    n_cmp++;
    if (ex_Valid_o !== 1'b1 || ex_Rd_o !== 5'd9) begin
      n_fail++;
      $display("FAIL hold_release v=%b rd=%0d exp v=1 rd=9", ex_Valid_o, ex_Rd_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_s = mk($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                1'($urandom), 1'($urandom), 3'($urandom), rand_reg(), rand_reg(), rand_reg());
      id_s.branch = 1'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end
  endtask

  task automatic test_async_reset_and_counters();
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd1, 5'd2, 5'd3);
    step(0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_v !== '0 || Stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%h stall=%b exp=0", dut_v, Stall_o);
    end
`ifdef ID_EX_PERF_CNT_EN
    n_cmp++;
    if (StallCnt_o !== 16'd0 || FlushCnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", StallCnt_o, FlushCnt_o);
    end
`endif
    #1;
    reset_n = 1'b1;
    m = '0;
    mdl_stall_cnt = 0;
    mdl_flush_cnt = 0;
    id_s = mk(1, 1, 1, 0, 1, 3'b000, 5'd0, 5'd0, 5'd1);   // first edge: normal load
    step(0, 0);
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd1, 5'd2, 5'd4);
    step(0, 0);
    step(0, 0);
    id_s = mk(1, 1, 1, 0, 1, 3'b000, 5'd0, 5'd0, 5'd2);
    step(0, 0);
    id_s = mk(1, 1, 0, 0, 1, 3'b010, 5'd2, 5'd0, 5'd5);
    step(0, 0);
    step(0, 0);
    id_s = mk(1, 0, 0, 0, 1, 3'b010, 5'd6, 5'd7, 5'd8);
    step(1, 0);
`ifdef ID_EX_PERF_CNT_EN
    n_cmp++;
    if (StallCnt_o !== 16'd2 || FlushCnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL perf_plan got=%0d/%0d exp=2/1", StallCnt_o, FlushCnt_o);
    end
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_zero_reg_and_store();
    test_flush_hold();
    test_hold_stall();
    test_random();
    test_async_reset_and_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the segmented ARMv8 core, directly downstream of the control unit and register file.
- Captures decoded control (ALUSrc, ALUOp, Branch, MemRead, MemWrite, MemtoReg, RegWrite), operands, immediate, PC and register addresses each cycle, and presents them to EX.
- Contains the load-use hazard detector. It stalls IF/ID and inserts a bubble, and it accepts flush (taken branch) and hold (downstream wait) requests.

Parameters:
- DATA_W, 64, operand/immediate/PC width
- REG_AW, 5, register address width
- ZERO_REG, 31, index of XZR; never creates a hazard

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- id_Valid_i  in  1  ID stage holds a real instruction
- id_ALUSrc_i, id_Branch_i, id_MemRead_i, id_MemWrite_i, id_MemtoReg_i, id_RegWrite_i  in  1 each  control from CU
- id_ALUOp_i  in  3  ALU operation from CU
- id_RD1_i, id_RD2_i, id_Imm_i, id_PC_i  in  DATA_W each  register data, sign-extended immediate, PC
- id_Rn_i, id_Rs2_i, id_Rd_i  in  REG_AW each  source 1, source 2 (already muxed by Reg2Loc), destination
- Flush_i  in  1  kill the instruction entering EX (taken branch)
- Hold_i  in  1  freeze EX contents (downstream wait)
- Stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
- ex_* outputs  out  same widths as the id_* inputs  registered copies, including ex_Valid_o

Behaviour:
- Reset (reset_n=0, async): every registered output is 0, including ex_Valid_o. Stall_o is 0 because it is derived from ex_Valid_o.
- Latency: 1 cycle; the ID inputs sampled at an edge appear on the ex_* outputs after that edge.
- Hazard (combinational): hz = ex_Valid_o & ex_MemRead_o & (ex_Rd_o != ZERO_REG) & (ex_Rd_o==id_Rn_i | (rs2_used & ex_Rd_o==id_Rs2_i)).
  - rs2_used = ~id_ALUSrc_i | id_MemWrite_i.
- Stall_o = id_Valid_i & hz.
- Per-edge update, in priority order:
  1. Flush_i=1: ex_Valid_o and all control outputs go to 0. Data/address outputs go to 0. Flush overrides Hold.
  2. Hold_i=1: all outputs retain their values. Stall_o still follows hz.
  3. Stall_o=1: bubble insertion. Control outputs and ex_Valid_o go to 0; data outputs go to 0.
  4. Otherwise: load all id_* inputs. Control bits are gated by id_Valid_i, so an invalid ID slot enters as all-zero control.
- A bubble clears ex_MemRead_o, so a single load-use hazard stalls exactly 1 cycle unless Hold_i extends it.
- Back-to-back loads: each dependent consumer stalls 1 cycle. An independent instruction after a load does not stall.
- Flush and Stall in the same cycle: the flush result applies; Stall_o is still reported that cycle.
- Reset deasserting mid-stream: the first edge after release performs a normal load.
- No X propagation: all outputs are defined after reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds two 16-bit saturating counters and output ports StallCnt_o[15:0] and FlushCnt_o[15:0].
  - StallCnt_o increments on every edge where Stall_o=1 and Hold_i=0.
  - FlushCnt_o increments on every edge where Flush_i=1 and ex_Valid_o=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Test Plan:
- Reset then ADD (id_Valid_i=1, ALUOp_i=3'b010, RegWrite_i=1, Rd=2, RD1=64'h5, RD2=64'h7) -> after 1 edge: ex_ALUOp_o=3'b010, ex_RegWrite_o=1, ex_Rd_o=2, ex_RD1_o=5, ex_Valid_o=1; Stall_o=0.
- LDUR X1 (MemRead=1, Rd=1) then ADD X2,X1,X3 (Rn=1) -> Stall_o=1 for exactly 1 cycle; next edge ex_Valid_o=0 and all control outputs 0; following edge the ADD is loaded.
- LDUR X31 followed by a consumer with Rn=31 -> Stall_o=0. STUR with Rs2=1 after LDUR X1 (ALUSrc=1, MemWrite=1) -> Stall_o=1.
- ADD loaded with Flush_i=1 and Hold_i=1 together -> ex_Valid_o=0 and all control outputs 0 after the edge.
- Valid LDUR held in EX with Hold_i=1 for 3 cycles while a dependent instruction waits in ID -> outputs unchanged and Stall_o=1 throughout. Release Hold_i -> one bubble, then the dependent instruction loads.
- reset_n pulsed low mid-cycle while ex_Valid_o=1 -> outputs 0 immediately, without waiting for a clock edge. With ID_EX_PERF_CNT_EN: 2 stalls and 1 flush -> StallCnt_o=2, FlushCnt_o=1.
